// File: rtl/ps_buffer_reader_pkg.sv
// Shared types for the PS shared-memory buffer reader.
// Clock/reset bundle, reader FSM states, shared-memory word width.
package MCPkg;

  localparam int SHMEM_DW = 32;

  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FLUSH
  } rdbuf_state_t;

endpackage

// File: rtl/ps_buffer_reader_rd_fifo.sv
// Synchronous FIFO for the buffer reader return path.
// Ports: clk_i, rst_ni, clr_i, wr_i/wdata_i, rd_i/rdata_o, count_o.
module rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clr_i,
  input  logic                           wr_i,
  input  logic [WIDTH-1:0]               wdata_i,
  input  logic                           rd_i,
  output logic [WIDTH-1:0]               rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wp_q;
  logic [PW-1:0]    rp_q;
  logic [CW-1:0]    cnt_q;
  logic             wr_ok;
  logic             rd_ok;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign wr_ok   = wr_i && (cnt_q != CW'(DEPTH));
  assign rd_ok   = rd_i && (cnt_q != '0);
  assign rdata_o = mem_q[rp_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_ok) wp_q <= inc(wp_q);
      if (rd_ok) rp_q <= inc(rp_q);
      unique case ({wr_ok, rd_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok && !clr_i) mem_q[wp_q] <= wdata_i;
  end

endmodule

// File: rtl/ps_buffer_reader.sv
// PL reader: fetches a word span from PS shared BRAM into a valid/ready stream.
// Ports: ClkRs_ix, start/base/len/abort, busy/done/err, mem_* BRAM port, data/valid/ready/last.
module ps_buffer_reader
  import MCPkg::*;
#(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  ckrs_t                ClkRs_ix,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [15:0]          len_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 mem_en_o,
  output logic [3:0]           mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [31:0]          mem_din_o,
  input  logic [SHMEM_DW-1:0]  mem_dout_i,
  output logic [SHMEM_DW-1:0]  data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 last_o
);

  localparam int L  = READ_LATENCY;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic clk;
  logic rst_n;
  assign clk   = ClkRs_ix.clk;
  assign rst_n = ClkRs_ix.reset;

  rdbuf_state_t state_q, state_d;

  logic [31:0]         base_q;
  logic [15:0]         len_q;
  logic [15:0]         issued_q;
  logic [1:0]          flush_q;
  logic                done_q;
  logic                err_q;
  logic [L-1:0]        vld_sh_q;
  logic [L-1:0]        lst_sh_q;

  logic                illegal;
  logic                accept;
  logic [15:0]         len_m1;
  logic [7:0]          occ;
  logic                credit_ok;
  logic                pop;
  logic                final_pop;
  logic                fifo_clr;
  logic                fifo_wr;
  logic [SHMEM_DW:0]   fifo_rdata;
  logic [CW-1:0]       fifo_cnt;

  assign illegal = (base_addr_i[1:0] != 2'b00)
                || (len_i == 16'd0)
                || (32'(len_i) > 32'(DEPTH_WORDS));
  assign accept  = (state_q == IDLE) && start_i && !illegal;
  assign len_m1  = len_q - 16'd1;

  // Credit: reads in flight plus words held must leave room in the FIFO.
  always_comb begin
    occ = 8'(fifo_cnt);
    for (int i = 0; i < L; i++) occ = occ + 8'(vld_sh_q[i]);
  end
  assign credit_ok = occ < 8'(FIFO_DEPTH);

  assign pop       = valid_o && ready_i;
  assign final_pop = pop && fifo_rdata[SHMEM_DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = READ;
      READ: begin
        if (abort_i)
          state_d = FLUSH;
        else if (mem_en_o && issued_q == len_m1)
          state_d = DRAIN;
      end
      // Hold DRAIN through the done pulse so busy drops one cycle later.
      DRAIN: begin
        if (done_q)
          state_d = IDLE;
        else if (abort_i && !final_pop)
          state_d = FLUSH;
      end
      FLUSH: if (flush_q == 2'(L - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o     = state_q != IDLE;
    mem_en_o   = (state_q == READ) && !abort_i && credit_ok;
    mem_addr_o = '0;
    if (mem_en_o) mem_addr_o = base_q + {14'd0, issued_q, 2'b00};
    fifo_clr   = state_q == FLUSH;
    fifo_wr    = vld_sh_q[L-1] && (state_q != FLUSH);
    valid_o    = (fifo_cnt != '0) && (state_q != FLUSH);
    data_o     = valid_o ? fifo_rdata[SHMEM_DW-1:0] : '0;
    last_o     = valid_o && fifo_rdata[SHMEM_DW];
  end

  assign done_o    = done_q;
  assign err_o     = err_q;
  assign mem_we_o  = '0;
  assign mem_din_o = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      flush_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      vld_sh_q <= '0;
      lst_sh_q <= '0;
    end else begin
      if (accept) begin
        base_q   <= base_addr_i;
        len_q    <= len_i;
        issued_q <= '0;
      end else if (mem_en_o) begin
        issued_q <= issued_q + 16'd1;
      end
      flush_q <= (state_q == FLUSH) ? flush_q + 2'd1 : 2'd0;
      done_q  <= final_pop && (state_q == DRAIN);
      err_q   <= (state_q == IDLE) && start_i && illegal;
      // Latency tracker: marks the cycle each read's data is on mem_dout_i.
      for (int i = 0; i < L; i++) begin
        if (i == 0) begin
          vld_sh_q[0] <= mem_en_o;
          lst_sh_q[0] <= mem_en_o && (issued_q == len_m1);
        end else begin
          vld_sh_q[i] <= vld_sh_q[i-1];
          lst_sh_q[i] <= lst_sh_q[i-1];
        end
      end
    end
  end

  rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SHMEM_DW + 1)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (fifo_clr),
    .wr_i    (fifo_wr),
    .wdata_i ({lst_sh_q[L-1], mem_dout_i}),
    .rd_i    (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_cnt)
  );

endmodule

// File: tb/tb_ps_buffer_reader.sv
// Scoreboard bench for ps_buffer_reader with a behavioural BRAM model.
// Expected beats/addresses are queued at request time; a monitor pops them.
module tb_ps_buffer_reader;
  import MCPkg::*;

  localparam int L    = 2;
  localparam int FD   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  ckrs_t       ckrs;
  logic        start_i = 1'b0;
  logic [31:0] base_i = '0;
  logic [15:0] len_i = '0;
  logic        abort_i = 1'b0;
  logic        ready_i = 1'b0;
  logic        busy_o, done_o, err_o, mem_en_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o, mem_din_o, mem_dout, data_o;
  logic        valid_o, last_o;

  assign ckrs.clk   = clk;
  assign ckrs.reset = rst_n;

  always #5 clk = ~clk;

  ps_buffer_reader #(
    .DEPTH_WORDS  (1024),
    .READ_LATENCY (L),
    .FIFO_DEPTH   (FD)
  ) dut (
    .ClkRs_ix    (ckrs),
    .start_i     (start_i),
    .base_addr_i (base_i),
    .len_i       (len_i),
    .abort_i     (abort_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_din_o   (mem_din_o),
    .mem_dout_i  (mem_dout),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .last_o      (last_o)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared memory: word at byte address a holds seed + a/4.
  logic [31:0] seed = '0;
  logic [31:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= mem_en_o ? seed + (mem_addr_o >> 2) : 32'hDEAD_BEEF;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_dout = pipe[L-1];

  logic [32:0] exp_q [$];
  logic [31:0] addr_q [$];
  int issued_n = 0, popped_n = 0, done_n = 0, err_n = 0;
  int start_cyc = 0, first_en = -1, first_val = -1, done_cyc = 0, err_cyc = 0;
  bit flushing = 0;
  bit pv = 0, pr = 0, pa = 0, prs = 0, pl = 0, pdone = 0;
  logic [31:0] pd = '0;
  int rmode = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic fail(input string nm, input logic [63:0] got);
    total++;
    bad++;
    $display("FAIL %s got=%0h want=none", nm, got);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_en_o) begin
        chk("credit", 64'((issued_n - popped_n) < FD), 64'(1));
        if (first_en < 0) first_en = cyc;
        if (addr_q.size() == 0) fail("unexpected_en", 64'(mem_addr_o));
        else chk("addr", 64'(mem_addr_o), 64'(addr_q.pop_front()));
        issued_n++;
      end
      if (valid_o && first_val < 0) first_val = cyc;
      if (flushing && valid_o) fail("valid_in_flush", 64'(data_o));
      if (pv && !pr && !pa && prs && !flushing)
        chk("hold", {31'd0, valid_o, last_o, data_o}, {31'd0, 1'b1, pl, pd});
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) fail("unexpected_beat", 64'(data_o));
        else chk("beat", 64'({last_o, data_o}), 64'(exp_q.pop_front()));
        popped_n++;
      end
      if (pdone) chk("busy_after_done", 64'(busy_o), 64'(0));
      if (done_o) begin
        done_n++;
        done_cyc = cyc;
        chk("busy_at_done", 64'(busy_o), 64'(1));
      end
      if (err_o) begin
        err_n++;
        err_cyc = cyc;
      end
      pv = valid_o; pr = ready_i; pa = abort_i; prs = 1'b1;
      pl = last_o; pd = data_o; pdone = done_o;
    end else begin
      pv = 0; prs = 0; pdone = 0;
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    case (rmode)
      0:       ready_i = 1'b1;
      1:       ready_i = ~ready_i;
      2:       ready_i = 1'($urandom_range(0, 1));
      default: ready_i = 1'b0;
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] b, input logic [15:0] n);
    base_i = b; len_i = n; start_i = 1'b1; start_cyc = cyc;
    tick();
    start_i = 1'b0;
  endtask

  task automatic issue(input logic [31:0] b, input int n, input logic [31:0] sd);
    logic [31:0] a;
    seed = sd;
    for (int i = 0; i < n; i++) begin
      a = b + 32'(4 * i);
      exp_q.push_back({(i == n - 1), sd + (a >> 2)});
      addr_q.push_back(a);
    end
    issued_n = 0; popped_n = 0; first_en = -1; first_val = -1;
    req(b, 16'(n));
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_n;
    int k = 0;
    while (done_n == d0 && k < budget) begin
      tick();
      k++;
    end
    if (done_n == d0) fail("done_timeout", 64'(k));
    repeat (3) tick();
    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    chk("addr_empty", 64'(addr_q.size()), 64'(0));
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {busy_o, done_o, err_o, mem_en_o, valid_o, last_o, data_o, mem_addr_o[25:0]}, 64'(0));
  endtask

  int exp_err = 0;
  int exp_done = 0;

  initial begin
    logic [31:0] b;
    int n, d0, k;
    repeat (3) tick();
    chk_zero("reset_outputs");
    chk("reset_wd", {mem_we_o, mem_din_o}, 64'(0));
    rst_n = 1'b1;
    repeat (2) tick();

    rmode = 0;
    issue(32'h100, 8, 32'hA500_0000);
    wait_done(100);
    exp_done++;
    chk("basic_first_en", 64'(first_en - start_cyc), 64'(1));
    chk("basic_first_val", 64'(first_val - start_cyc), 64'(2 + L));
    chk("basic_done_cyc", 64'(done_cyc - start_cyc), 64'(8 + 2 + L));

    rmode = 1;
    issue(32'h2000, 16, $urandom);
    repeat (3) tick();
    req(32'h3, 16'd5);
    wait_done(300);
    exp_done++;

    rmode = 0;
    for (int t = 0; t < 3; t++) begin
      d0 = err_n;
      case (t)
        0:       req(32'h102, 16'd4);
        1:       req(32'h200, 16'd0);
        default: req(32'h200, 16'd1025);
      endcase
      exp_err++;
      repeat (3) tick();
      chk("err_pulse", 64'(err_n - d0), 64'(1));
      chk("err_cyc", 64'(err_cyc - start_cyc), 64'(1));
      chk("err_busy", 64'(busy_o), 64'(0));
    end

    issue(32'hFFFF_FFF8, 4, $urandom);
    wait_done(100);
    exp_done++;

    issue(32'h400, 10, $urandom);
    k = 0;
    while (popped_n < 3 && k < 60) begin
      tick();
      k++;
    end
    if (popped_n < 3) fail("abort_pop_timeout", 64'(popped_n));
    d0 = done_n;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    flushing = 1;
    exp_q.delete();
    addr_q.delete();
    repeat (8) tick();
    chk("abort_busy", 64'(busy_o), 64'(0));
    chk("abort_no_done", 64'(done_n - d0), 64'(0));
    flushing = 0;
    issue(32'h800, 5, $urandom);
    wait_done(100);
    exp_done++;

    issue(32'h1000, 20, $urandom);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk_zero("midreset_outputs");
    exp_q.delete();
    addr_q.delete();
    flushing = 1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    flushing = 0;
    issue(32'h1800, 6, $urandom);
    wait_done(100);
    exp_done++;

    for (int r = 0; r < 6; r++) begin
      rmode = $urandom_range(0, 2);
      b = $urandom;
      b[1:0] = 2'b00;
      n = (r == 0) ? 1 : $urandom_range(1, 40);
      issue(b, n, $urandom);
      wait_done(n * 8 + 60);
      exp_done++;
    end

    rmode = 0;
    issue(32'h0, 1024, $urandom);
    wait_done(1200);
    exp_done++;

    chk("err_total", 64'(err_n), 64'(exp_err));
    chk("done_total", 64'(done_n), 64'(exp_done));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
